// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_seq_pkg;

   localparam int unsigned SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_ROTR = 2'b10,
      OP_SRA  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between the execute-stage pipeline and the shift sequencer.
interface shift_seq_ctrl_if;
   import shift_seq_pkg::*;

   logic               start;
   logic               flush;
   op_e                op;
   logic [SHAMT_W-1:0] shamt;
   logic [31:0]        din;
   logic               busy;
   logic               done;
   logic [31:0]        dout;

   modport master (
      output start, flush, op, shamt, din,
      input  busy, done, dout
   );

   modport slave (
      input  start, flush, op, shamt, din,
      output busy, done, dout
   );

endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter by k (0..STEP) bits.
// Rotate feedback exists only when SHIFT_SEQ_ROTR_EN is defined; otherwise ROTR acts as SRL.
module shift_step
   import shift_seq_pkg::*;
#(
   parameter int unsigned STEP = 4,
   localparam int unsigned KW  = $clog2(STEP + 1)
) (
   input  logic [31:0]   data,
   input  logic [KW-1:0] k,
   input  op_e           op,
   input  logic          sign,
   output logic [31:0]   result
);

   logic [31:0] fill_mask;
`ifdef SHIFT_SEQ_ROTR_EN
   logic [5:0]  rot_amt;
`endif

   always_comb begin
      // Vacated high bits after a right shift by k
      fill_mask = ~(32'hFFFF_FFFF >> k);
`ifdef SHIFT_SEQ_ROTR_EN
      rot_amt   = 6'd32 - 6'(k);
`endif
      case (op)
         OP_SLL:  result = data << k;
         OP_SRA:  result = (data >> k) | (fill_mask & {32{sign}});
`ifdef SHIFT_SEQ_ROTR_EN
         OP_ROTR: result = (data >> k) | (data << rot_amt);
`endif
         default: result = data >> k;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: iterates shift_step until shamt is consumed, then pulses done.
// Optional rotate support: define SHIFT_SEQ_ROTR_EN.
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int unsigned STEP = 4
) (
   input logic             clk,
   input logic             reset_n,
   shift_seq_ctrl_if.slave bus
);

   localparam int unsigned KW = $clog2(STEP + 1);

   if (!(STEP inside {1, 2, 4, 8, 16})) begin : g_bad_step
      $error("shift_seq_ctrl: STEP must be 1, 2, 4, 8 or 16");
   end

   state_e             state_q;
   op_e                op_q;
   logic               sign_q;
   logic [31:0]        work_q;
   logic [SHAMT_W-1:0] rem_q;
   logic               busy_q;
   logic               done_q;
   logic [31:0]        dout_q;

   logic [KW-1:0]      k;
   logic [SHAMT_W-1:0] rem_d;
   logic [31:0]        step_out;

   assign k     = (rem_q > SHAMT_W'(STEP)) ? KW'(STEP) : KW'(rem_q);
   assign rem_d = rem_q - SHAMT_W'(k);

   shift_step #(
      .STEP (STEP)
   ) u_step (
      .data   (work_q),
      .k      (k),
      .op     (op_q),
      .sign   (sign_q),
      .result (step_out)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
         op_q    <= OP_SLL;
         sign_q  <= 1'b0;
         work_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               StIdle, StDone: begin
                  if (bus.start) begin
                     op_q   <= bus.op;
                     sign_q <= bus.din[31];
                     work_q <= bus.din;
                     rem_q  <= bus.shamt;
                     if (bus.shamt == '0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dout_q  <= bus.din;
                     end else begin
                        state_q <= StShift;
                        busy_q  <= 1'b1;
                     end
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end
               StShift: begin
                  // start is deliberately not looked at here; it is not queued
                  work_q <= step_out;
                  rem_q  <= rem_d;
                  if (rem_d == '0) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     dout_q  <= step_out;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dout = dout_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: driver pushes expected results, monitor checks on done.
module tb_shift_seq_ctrl;
   import shift_seq_pkg::*;

   localparam int unsigned STEP = 4;

   typedef struct {
      logic [31:0] val;
      int          cyc;
      int          lat;
   } exp_t;

   logic        clk;
   logic        reset_n;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [31:0] last_dout = '0;

   shift_seq_ctrl_if bus ();

   shift_seq_ctrl #(
      .STEP (STEP)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int lat(input int s);
      return (s + STEP - 1) / STEP;
   endfunction

   // Reference result straight from the instruction semantics
   function automatic logic [31:0] ref_shift(input logic [1:0] o, input int s,
                                             input logic [31:0] d);
      case (o)
         2'b00: return d << s;
         2'b11: return 32'($signed(d) >>> s);
`ifdef SHIFT_SEQ_ROTR_EN
         2'b10: return (d >> s) | (d << (32 - s));
`endif
         default: return d >> s;
      endcase
   endfunction

   // Monitor: checks result, completion cycle and busy duration on every done pulse
   initial begin
      int   busy_cnt;
      bit   abort;
      exp_t e;
      busy_cnt = 0;
      forever begin
         @(posedge clk);
         abort = bus.flush || !reset_n;
         #1;
         if (abort) busy_cnt = 0;
         if (bus.done === 1'b1) begin
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("dout", bus.dout, e.val);
               check("done_cycle", 32'(cyc), 32'(e.cyc));
               check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
            end
            busy_cnt = 0;
         end else if (bus.busy === 1'b1) begin
            busy_cnt++;
         end
      end
   end

   // Issue one op at a negedge; returns after the edge that completes it
   task automatic start_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                           input logic [31:0] expv);
      exp_t e;
      int   l;
      l          = lat(int'(s));
      bus.start  = 1'b1;
      bus.flush  = 1'b0;
      bus.op     = op_e'(o);
      bus.shamt  = s;
      bus.din    = d;
      e.val      = expv;
      e.cyc      = cyc + 1 + l;
      e.lat      = l;
      exp_q.push_back(e);
      last_dout  = expv;
      @(negedge clk);
      // Junk requests while shifting must be ignored
      repeat (l) begin
         bus.start = 1'($urandom);
         bus.op    = op_e'(2'($urandom));
         bus.shamt = 5'($urandom);
         bus.din   = $urandom;
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         bus.start = 1'($urandom);
         bus.flush = bus.start | 1'($urandom);
         bus.din   = $urandom;
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic random_op();
      logic [1:0] o;
      logic [4:0] s;
      logic [31:0] d;
      o = 2'($urandom);
      case ($urandom_range(0, 3))
         0:       s = 5'd0;
         1:       s = 5'd31;
         2:       s = 5'(STEP * $urandom_range(1, 7));
         default: s = 5'($urandom);
      endcase
      d = $urandom;
      start_op(o, s, d, ref_shift(o, int'(s), d));
   endtask

   // Abort a shamt=20 op during its third SHIFT cycle
   task automatic abort_op(input bit use_reset);
      bus.start = 1'b1;
      bus.op    = op_e'(2'($urandom));
      bus.shamt = 5'd20;
      bus.din   = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      if (use_reset) reset_n = 1'b0;
      else bus.flush = 1'b1;
      @(negedge clk);
      reset_n   = 1'b1;
      bus.flush = 1'b0;
      if (use_reset) last_dout = '0;
      check(use_reset ? "reset_abort_busy" : "flush_busy", 32'(bus.busy), 32'd0);
      check(use_reset ? "reset_abort_done" : "flush_done", 32'(bus.done), 32'd0);
      check(use_reset ? "reset_abort_dout" : "flush_dout", bus.dout, last_dout);
      repeat (8) @(negedge clk);
      check("abort_idle_busy", 32'(bus.busy), 32'd0);
      check("abort_hold_dout", bus.dout, last_dout);
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = OP_SLL;
      bus.shamt = '0;
      bus.din   = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_dout", bus.dout, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      start_op(2'b11, 5'd4, 32'h8000_0000, 32'hF800_0000);
      gap(2);
      start_op(2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      gap(1);
      start_op(2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
      gap(1);
      start_op(2'b00, 5'd5, 32'h0000_0001, 32'h0000_0020);
      start_op(2'b11, 5'd0, 32'h7FFF_FFF0, 32'h7FFF_FFF0);
      gap(2);
`ifdef SHIFT_SEQ_ROTR_EN
      start_op(2'b10, 5'd4, 32'h0000_000F, 32'hF000_0000);
`else
      start_op(2'b10, 5'd4, 32'h0000_000F, 32'h0000_0000);
`endif
      gap(2);
      abort_op(1'b0);
      abort_op(1'b1);

      for (int i = 0; i < 80; i++) begin
         random_op();
         if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
      end
      gap(0);
      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
